// File: rtl/qnet_rx_deframer.sv
// QICK network RX deframer: rebuilds 1/2-beat commands from the Aurora RX stream.
// Optional destination filter: define QNET_RX_FILTER_EN.
module qnet_rx_deframer #(
  parameter int CNT_W = 16
) (
  input  logic             t_clk_i,
  input  logic             t_rst_ni,
  input  logic [9:0]       id_i,
  input  logic [47:0]      t_time_abs,
  input  logic             rx_tvalid_i,
  input  logic [63:0]      rx_tdata_i,
  input  logic             rx_tlast_i,
  output logic             cmd_net_o,
  output logic [63:0]      cmd_h_o,
  output logic [63:0]      cmd_dt_o,
  output logic [31:0]      cmd_time_o,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic [7:0]       err_cnt_o,
  output logic [1:0]       err_code_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [63:0]      r_hdr;
  logic [31:0]      r_time;
  logic             r_pass;
  logic             r_cmd_net;
  logic [63:0]      r_cmd_h;
  logic [63:0]      r_cmd_dt;
  logic [31:0]      r_cmd_time;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [7:0]       r_err_cnt;
  logic [1:0]       r_err_code;

  logic        w_hd;
  logic        w_pass;
  logic        w_hdr_ld;
  logic        w_deliver;
  logic        w_err;
  logic [1:0]  w_err_code;
  logic [63:0] w_cmd_h;
  logic [63:0] w_cmd_dt;
  logic [31:0] w_cmd_time;

  assign w_hd = rx_tdata_i[63];

`ifdef QNET_RX_FILTER_EN
  assign w_pass = (rx_tdata_i[9:0] == id_i)
               || (rx_tdata_i[9:0] == 10'h3FF);
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, t_time_abs[47:32]};
`else
  assign w_pass = 1'b1;
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, t_time_abs[47:32], id_i};
`endif

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) r_state <= IDLE;
    else           r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (rx_tvalid_i) begin
      unique case (r_state)
        IDLE: begin
          if (!w_hd && !rx_tlast_i)     w_nxt = DROP;
          else if (w_hd && !rx_tlast_i) w_nxt = DATA;
        end
        DATA:    w_nxt = rx_tlast_i ? IDLE : DROP;
        DROP:    if (rx_tlast_i) w_nxt = IDLE;
        default: w_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_hdr_ld   = 1'b0;
    w_deliver  = 1'b0;
    w_err      = 1'b0;
    w_err_code = 2'd0;
    w_cmd_h    = rx_tdata_i;
    w_cmd_dt   = 64'd0;
    w_cmd_time = t_time_abs[31:0];
    if (rx_tvalid_i) begin
      unique case (r_state)
        IDLE: begin
          w_hdr_ld = 1'b1;
          unique case ({w_hd, rx_tlast_i})
            2'b01:   w_deliver = w_pass;
            2'b00: begin
              w_err      = 1'b1;
              w_err_code = 2'd2;
            end
            2'b11: begin
              w_err      = 1'b1;
              w_err_code = 2'd1;
            end
            default: ;
          endcase
        end
        DATA: begin
          // Data beat completes the packet out of the holding registers
          w_cmd_h    = r_hdr;
          w_cmd_dt   = rx_tdata_i;
          w_cmd_time = r_time;
          if (rx_tlast_i) begin
            w_deliver = r_pass;
          end else begin
            w_err      = 1'b1;
            w_err_code = 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      r_hdr      <= '0;
      r_time     <= '0;
      r_pass     <= 1'b0;
      r_cmd_net  <= 1'b0;
      r_cmd_h    <= '0;
      r_cmd_dt   <= '0;
      r_cmd_time <= '0;
      r_pkt_cnt  <= '0;
      r_err_cnt  <= '0;
      r_err_code <= '0;
    end else begin
      r_cmd_net <= w_deliver;
      if (w_hdr_ld) begin
        r_hdr  <= rx_tdata_i;
        r_time <= t_time_abs[31:0];
        r_pass <= w_pass;
      end
      if (w_deliver) begin
        r_cmd_h    <= w_cmd_h;
        r_cmd_dt   <= w_cmd_dt;
        r_cmd_time <= w_cmd_time;
        r_pkt_cnt  <= r_pkt_cnt + 1'b1;
      end
      if (w_err) begin
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        r_err_code <= w_err_code;
      end
    end
  end

  assign cmd_net_o  = r_cmd_net;
  assign cmd_h_o    = r_cmd_h;
  assign cmd_dt_o   = r_cmd_dt;
  assign cmd_time_o = r_cmd_time;
  assign pkt_cnt_o  = r_pkt_cnt;
  assign err_cnt_o  = r_err_cnt;
  assign err_code_o = r_err_code;
  assign state_o    = r_state;

endmodule

// File: tb/tb_qnet_rx_deframer.sv
// Directed bench for qnet_rx_deframer.
// Filter cases run when QNET_RX_FILTER_EN is defined.
module tb_qnet_rx_deframer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  id;
  logic [47:0] tabs;
  logic        vld;
  logic [63:0] dat;
  logic        lst;
  logic        net;
  logic [63:0] ch;
  logic [63:0] cdt;
  logic [31:0] ctm;
  logic [15:0] pcnt;
  logic [7:0]  ecnt;
  logic [1:0]  ecode;
  logic [1:0]  st;

  int n_cmp = 0;
  int n_bad = 0;

  qnet_rx_deframer #(.CNT_W(16)) dut (
    .t_clk_i    (clk),
    .t_rst_ni   (rst_n),
    .id_i       (id),
    .t_time_abs (tabs),
    .rx_tvalid_i(vld),
    .rx_tdata_i (dat),
    .rx_tlast_i (lst),
    .cmd_net_o  (net),
    .cmd_h_o    (ch),
    .cmd_dt_o   (cdt),
    .cmd_time_o (ctm),
    .pkt_cnt_o  (pcnt),
    .err_cnt_o  (ecnt),
    .err_code_o (ecode),
    .state_o    (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tabs <= tabs + 48'd1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks at a falling edge
  // see the result of the preceding rising edge.
  task automatic step(input logic v,
                      input logic [63:0] d,
                      input logic l);
    @(negedge clk);
    vld = v;
    dat = d;
    lst = l;
  endtask

  logic [31:0] t0, t1, t2, t3;

  initial begin
    tabs  = 48'hABCD_1000_0100;
    rst_n = 1'b0;
    id    = 10'd3;
    vld   = 1'b0;
    dat   = '0;
    lst   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_net", 64'(net), 64'd0);
    chk("rst_h", ch, 64'd0);
    chk("rst_dt", cdt, 64'd0);
    chk("rst_time", 64'(ctm), 64'd0);
    chk("rst_pkt", 64'(pcnt), 64'd0);
    chk("rst_err", 64'(ecnt), 64'd0);
    chk("rst_code", 64'(ecode), 64'd0);
    chk("rst_state", 64'(st), 64'd0);
    rst_n = 1'b1;

    // single 1-beat packet
    step(1, 64'h0000_0000_0150_0403, 1);
    t0 = tabs[31:0];
    step(0, 64'd0, 0);
    chk("p1_net", 64'(net), 64'd1);
    chk("p1_h", ch, 64'h0000_0000_0150_0403);
    chk("p1_dt", cdt, 64'd0);
    chk("p1_time", 64'(ctm), 64'(t0));
    chk("p1_pkt", 64'(pcnt), 64'd1);
    step(0, 64'd0, 0);
    chk("p1_net_off", 64'(net), 64'd0);
    chk("p1_h_hold", ch, 64'h0000_0000_0150_0403);

    // 2-beat packet immediately followed by a 1-beat packet
    step(1, 64'h8000_0000_0150_0403, 0);
    t1 = tabs[31:0];
    step(1, 64'hDEAD_BEEF_0123_4567, 1);
    chk("b2b_c2_net", 64'(net), 64'd0);
    chk("b2b_c2_state", 64'(st), 64'd1);
    step(1, 64'h0000_0000_0020_07FF, 1);
    t2 = tabs[31:0];
    chk("b2b_s1_net", 64'(net), 64'd1);
    chk("b2b_s1_h", ch, 64'h8000_0000_0150_0403);
    chk("b2b_s1_dt", cdt, 64'hDEAD_BEEF_0123_4567);
    chk("b2b_s1_time", 64'(ctm), 64'(t1));
    chk("b2b_s1_pkt", 64'(pcnt), 64'd2);
    step(0, 64'd0, 0);
    chk("b2b_s2_net", 64'(net), 64'd1);
    chk("b2b_s2_h", ch, 64'h0000_0000_0020_07FF);
    chk("b2b_s2_dt", cdt, 64'd0);
    chk("b2b_s2_time", 64'(ctm), 64'(t2));
    chk("b2b_s2_pkt", 64'(pcnt), 64'd3);
    step(0, 64'd0, 0);
    chk("b2b_off", 64'(net), 64'd0);

    // short packet
    step(1, 64'h8000_0000_0150_0403, 1);
    step(0, 64'd0, 0);
    chk("short_net", 64'(net), 64'd0);
    chk("short_err", 64'(ecnt), 64'd1);
    chk("short_code", 64'(ecode), 64'd1);
    chk("short_state", 64'(st), 64'd0);
    chk("short_h", ch, 64'h0000_0000_0020_07FF);

    // long packet: header + 2 beats
    step(1, 64'h0000_0000_0150_0403, 0);
    step(1, 64'h1111_2222_3333_4444, 0);
    chk("long_state1", 64'(st), 64'd2);
    chk("long_err", 64'(ecnt), 64'd2);
    chk("long_code", 64'(ecode), 64'd2);
    step(1, 64'h5555_6666_7777_8888, 1);
    chk("long_state2", 64'(st), 64'd2);
    chk("long_net", 64'(net), 64'd0);
    step(1, 64'h0000_0000_00A0_0C03, 1);
    t3 = tabs[31:0];
    chk("long_state3", 64'(st), 64'd0);
    chk("long_pkt", 64'(pcnt), 64'd3);
    step(0, 64'd0, 0);
    chk("after_net", 64'(net), 64'd1);
    chk("after_h", ch, 64'h0000_0000_00A0_0C03);
    chk("after_time", 64'(ctm), 64'(t3));
    chk("after_pkt", 64'(pcnt), 64'd4);
    chk("after_code", 64'(ecode), 64'd2);

    // 2-beat packet whose data beat lacks tlast
    step(1, 64'h8000_0000_0150_0403, 0);
    step(1, 64'h9999_9999_9999_9999, 0);
    step(0, 64'd0, 0);
    chk("dlong_state", 64'(st), 64'd2);
    chk("dlong_err", 64'(ecnt), 64'd3);
    chk("dlong_net", 64'(net), 64'd0);
    step(1, 64'h0, 1);
    step(0, 64'd0, 0);
    chk("dlong_idle", 64'(st), 64'd0);
    chk("dlong_pkt", 64'(pcnt), 64'd4);

`ifdef QNET_RX_FILTER_EN
    step(1, 64'h0000_0000_0150_0405, 1);
    step(0, 64'd0, 0);
    chk("flt5_net", 64'(net), 64'd0);
    chk("flt5_pkt", 64'(pcnt), 64'd4);
    step(1, 64'h8000_0000_0150_0405, 0);
    step(1, 64'h1234, 1);
    step(0, 64'd0, 0);
    chk("flt5b_net", 64'(net), 64'd0);
    chk("flt5b_state", 64'(st), 64'd0);
    step(1, 64'h0000_0000_0150_0403, 1);
    step(0, 64'd0, 0);
    chk("flt3_net", 64'(net), 64'd1);
    step(1, 64'h8000_0000_0150_07FF, 0);
    step(1, 64'h00C0_FFEE, 1);
    step(0, 64'd0, 0);
    chk("flt3ff_net", 64'(net), 64'd1);
    chk("flt3ff_dt", cdt, 64'h00C0_FFEE);
    chk("flt_pkt", 64'(pcnt), 64'd6);
    chk("flt_err", 64'(ecnt), 64'd3);
`else
    step(1, 64'h0000_0000_0150_0405, 1);
    step(0, 64'd0, 0);
    chk("nof5_net", 64'(net), 64'd1);
    chk("nof5_h", ch, 64'h0000_0000_0150_0405);
    chk("nof5_pkt", 64'(pcnt), 64'd5);
    chk("nof5_err", 64'(ecnt), 64'd3);
`endif

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      step(1, 64'h8000_0000_0000_0003, 1);
    end
    step(0, 64'd0, 0);
    chk("sat_err", 64'(ecnt), 64'd255);
    chk("sat_code", 64'(ecode), 64'd1);
    chk("sat_net", 64'(net), 64'd0);

    // asynchronous reset while in DATA
    step(1, 64'h8000_0000_0150_0403, 0);
    step(0, 64'd0, 0);
    chk("mid_state", 64'(st), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_state", 64'(st), 64'd0);
    chk("arst_h", ch, 64'd0);
    chk("arst_dt", cdt, 64'd0);
    chk("arst_time", 64'(ctm), 64'd0);
    chk("arst_pkt", 64'(pcnt), 64'd0);
    chk("arst_err", 64'(ecnt), 64'd0);
    chk("arst_code", 64'(ecode), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 64'h0000_0000_0150_0403, 1);
    step(0, 64'd0, 0);
    chk("post_net", 64'(net), 64'd1);
    chk("post_dt", cdt, 64'd0);
    chk("post_pkt", 64'(pcnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qnet_rx_deframer.md
# qnet_rx_deframer

Receive-side packet deframer for the simplex QICK network link. It consumes the 64-bit AXI-Stream beats delivered by the channel-A Aurora RX core and rebuilds 1- or 2-beat network commands. It checks each packet's length and emits a registered header/data pair with a single-cycle hit strobe, plus an arrival timestamp. Its outputs feed the command decoder's network-command inputs.

## Interface
Parameters:
- `CNT_W`, default 16: width of the received-packet counter.

Ports:
- `t_clk_i`  in  1  time clock; the only clock.
- `t_rst_ni`  in  1  asynchronous, active-low reset.
- `id_i`  in  10  this node's ID.
- `t_time_abs`  in  48  absolute time.
- `rx_tvalid_i`  in  1  RX beat valid. There is no backpressure; every valid beat is consumed.
- `rx_tdata_i`  in  64  RX beat data.
- `rx_tlast_i`  in  1  last beat of a packet.
- `cmd_net_o`  out  1  one-cycle strobe: a new command is valid.
- `cmd_h_o`  out  64  command header.
- `cmd_dt_o`  out  64  command data; zero for header-only packets.
- `cmd_time_o`  out  32  `t_time_abs[31:0]` sampled on the header beat.
- `pkt_cnt_o`  out  CNT_W  delivered-packet counter; wraps.
- `err_cnt_o`  out  8  framing-error counter; saturates at 255.
- `err_code_o`  out  2  last error: 0 none, 1 short, 2 long.
- `state_o`  out  2  FSM state, for debug.

## Operation
Header format:
- `[63]`: has-data flag (HD). HD=1 means a 2-beat packet; HD=0 means a 1-beat packet.
- `[24:20]`: opcode.
- `[19:10]`: source ID.
- `[9:0]`: destination ID. The value 0x3FF is broadcast.
- The block does not interpret any other header bits.

FSM states (`state_o` encoding):
- IDLE (0)
- DATA (1)
- DROP (2)

IDLE, on a valid beat (the beat is the header):
- Latch the beat into the header holding register.
- Latch `t_time_abs[31:0]` into the time holding register.
- HD=0 with tlast=1: deliver.
- HD=0 with tlast=0: long error; go to DROP.
- HD=1 with tlast=1: short error; discard; stay in IDLE.
- HD=1 with tlast=0: go to DATA.

DATA, on a valid beat:
- Latch the beat as data.
- tlast=1: deliver; go to IDLE.
- tlast=0: long error; go to DROP.

DROP:
- Discard valid beats.
- On a beat with tlast=1, go to IDLE. That tlast beat is discarded.

Deliver:
- Load `cmd_h_o`, `cmd_dt_o` and `cmd_time_o` from the holding registers and the current beat.
- Pulse `cmd_net_o`.
- Increment `pkt_cnt_o`.

Error:
- Increment `err_cnt_o`, saturating.
- Set `err_code_o`. It holds until the next error or reset.
- Do not load the outputs and do not pulse `cmd_net_o`.

`tvalid` low in any state: hold the state; no action.

## Timing
- Reset values: every output is 0, the state is IDLE, and the holding registers are 0.
- Delivery latency: `cmd_net_o` is high in the cycle after the tlast beat is sampled.
- `cmd_h_o`, `cmd_dt_o` and `cmd_time_o` update in the same cycle as the strobe and stay stable until the next delivery.
- Back-to-back traffic:
  - `tvalid` may be high every cycle.
  - A header beat arriving in the strobe cycle is accepted normally.
  - Full rate is one 1-beat packet per cycle, or one 2-beat packet per two cycles.
- The counter increment and the strobe occur in the same cycle.
- If a delivery and an error fall in the same cycle, both are applied.
- Reset during a packet: the FSM returns asynchronously to IDLE. After reset release, the next valid beat is taken as a header, even if it is the remainder of the interrupted packet.
- `id_i` is static in normal operation. It is sampled combinationally only when the filter is enabled, on the header beat.

## Configuration
`QNET_RX_FILTER_EN`:
- Defined: on the header beat, a packet whose destination is neither `id_i` nor 0x3FF is filtered.
  - The FSM still tracks its length: DATA/DROP transitions and the short/long error checks are unchanged.
  - At its end there is no delivery: no strobe and no `pkt_cnt_o` increment.
  - It is not counted as an error.
- Undefined: all well-formed packets are delivered, whatever their destination; `id_i` is unused.

## Test plan
- Single 1-beat packet: header 0x0000_0000_0150_0403 with tlast=1. Required: one cycle later `cmd_net_o`=1 for exactly one cycle, `cmd_h_o`=0x0000_0000_0150_0403, `cmd_dt_o`=0, `cmd_time_o` equal to time at the header beat, `pkt_cnt_o`=1.
- 2-beat packet, then a 1-beat packet in the very next cycle (three consecutive valid cycles):
  - Packet 1: header with HD=1, then data 0xDEAD_BEEF_0123_4567 with tlast=1.
  - Required: two strobes, in cycles 3 and 4.
  - Required: the first strobe carries data 0xDEAD_BEEF_0123_4567.
  - Required: `pkt_cnt_o`=2.
- Short packet (HD=1 header with tlast=1) -> no strobe, `err_cnt_o`=1, `err_code_o`=1, state stays IDLE.
- Long packet (HD=0 header, tlast=0, then 2 beats ending in tlast) -> no strobe, `err_code_o`=2, state passes through DROP. A following good packet is delivered normally.
- 300 short packets -> `err_cnt_o` saturates at 255.
- With `QNET_RX_FILTER_EN` and `id_i`=3: destination 5 gives no strobe; destination 3 and destination 0x3FF each give a strobe; `err_cnt_o` stays 0. Also assert `t_rst_ni` low in DATA and check that all outputs clear immediately.
